noc_outport_alloc: RTL

- Per-output-port switch allocator for the NoC router. One instance sits at each output port.
- Generalises the 5-port output mux controller to NPORT inputs and multi-flit wormhole packets with head/tail framing.
- Uses credit-based flow control toward the downstream buffer and a round-robin arbiter with a rotating pointer.
- Drives the crossbar select and the per-input grant/pop signals.

---
 rtl/noc_pkg.sv | 12 +
 rtl/noc_outport_alloc_if.sv | 10 +
 rtl/rr_arb.sv | 28 ++
 rtl/noc_outport_alloc.sv | 111 +++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared router constants, default sizes and allocator state encoding.
package noc_pkg;
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
   localparam int NPORT_DEF = 5;
   localparam int DESTW_DEF = 3;
   localparam int DEPTH_DEF = 4;
   localparam int LOCAL = 0;
   localparam int N = 1;
   localparam int E = 2;
   localparam int S = 3;
   localparam int W = 4;
endpackage

// File: rtl/noc_outport_alloc_if.sv
// noc_outport_alloc_if: per-input flit request bundle and the grant/pop vector back.
interface noc_outport_alloc_if #(parameter int NPORT = 5, parameter int DESTW = 3);
   logic [NPORT*DESTW-1:0] dest_i;
   logic [NPORT-1:0]       req_i;
   logic [NPORT-1:0]       head_i;
   logic [NPORT-1:0]       tail_i;
   logic [NPORT-1:0]       gnt_o;
   modport master (output dest_i, req_i, head_i, tail_i, input gnt_o);
   modport slave (input dest_i, req_i, head_i, tail_i, output gnt_o);
endinterface

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin pick of the first request at or after ptr.
module rr_arb #(
   parameter int N    = 5,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   input  logic            en,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] idx
);
   logic [IDXW-1:0] pos [N];
   for (genvar g = 0; g < N; g++) begin : g_pos
      assign pos[g] = IDXW'((int'(ptr) + g) % N);
   end
   // descending scan so the smallest offset from ptr wins
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (en && req[pos[k]]) begin
            gnt         = '0;
            gnt[pos[k]] = 1'b1;
            idx         = pos[k];
         end
      end
   end
endmodule

// File: rtl/noc_outport_alloc.sv
// noc_outport_alloc: wormhole output-port allocator with credits and round-robin heads.
// Define OUTPORT_STATS_EN to add the packet and stall counters.
module noc_outport_alloc
   import noc_pkg::*;
#(
   parameter int NPORT  = NPORT_DEF,
   parameter int DESTW  = DESTW_DEF,
   parameter int PORTID = 0,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int IDXW   = $clog2(NPORT),
   parameter int CRDW   = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_,
   noc_outport_alloc_if.slave  bus,
   input  logic                cred_ret_i,
   output logic [IDXW-1:0]     owner_o,
   output logic                busy_o,
   output logic [CRDW-1:0]     credit_o,
   output logic                cred_err_o
`ifdef OUTPORT_STATS_EN
   ,
   output logic [15:0]         pkt_cnt_o,
   output logic [15:0]         stall_cnt_o
`endif
);
   state_t            state_q, state_d;
   logic [IDXW-1:0]   owner_q, owner_d, ptr_q, ptr_d, win;
   logic [CRDW-1:0]   credit_q, credit_d;
   logic              err_q, err_d;
   logic [NPORT-1:0]  cand, arb_gnt, gnt;
   logic              crd_ok, fire, last;

   for (genvar g = 0; g < NPORT; g++) begin : g_cand
      assign cand[g] = bus.req_i[g] && bus.dest_i[g*DESTW +: DESTW] == DESTW'(PORTID);
   end

   assign crd_ok = credit_q != '0;

   rr_arb #(.N(NPORT), .IDXW(IDXW)) u_arb (
      .req (cand & bus.head_i),
      .ptr (ptr_q),
      .en  (state_q == IDLE && crd_ok),
      .gnt (arb_gnt),
      .idx (win)
   );

   // body flits carry no valid dest, so the locked owner bypasses the match
   always_comb begin
      gnt = '0;
      if (rst_) begin
         if (state_q == IDLE) gnt = arb_gnt;
         else gnt[owner_q] = bus.req_i[owner_q] & crd_ok;
      end
   end

   assign bus.gnt_o = gnt;
   assign fire      = |gnt;
   assign last      = state_q == IDLE ? bus.tail_i[win] : bus.tail_i[owner_q];

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      if (fire && state_q == IDLE) begin
         owner_d = win;
         ptr_d   = win == IDXW'(NPORT - 1) ? '0 : win + 1'b1;
      end
      if (fire) state_d = last ? IDLE : LOCKED;
      credit_d = fire && !cred_ret_i ? credit_q - 1'b1
               : !fire && cred_ret_i && credit_q != CRDW'(DEPTH) ? credit_q + 1'b1
               : credit_q;
      err_d    = err_q | (cred_ret_i && !fire && credit_q == CRDW'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         ptr_q    <= '0;
         credit_q <= CRDW'(DEPTH);
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

   assign owner_o    = owner_q;
   assign busy_o     = state_q == LOCKED;
   assign credit_o   = credit_q;
   assign cred_err_o = err_q;

`ifdef OUTPORT_STATS_EN
   logic [15:0] pkt_q, stall_q;
   always_ff @(posedge clk) begin
      if (!rst_) begin
         pkt_q   <= '0;
         stall_q <= '0;
      end else begin
         if (fire && last) pkt_q <= pkt_q + 1'b1;
         if (|cand && !crd_ok && stall_q != '1) stall_q <= stall_q + 1'b1;
      end
   end
   assign pkt_cnt_o   = pkt_q;
   assign stall_cnt_o = stall_q;
`endif
endmodule
